glb_netwk_sched: RTL
====================

Name: glb_netwk_sched

Overview:
- Scheduler that shares the eight iCE40 global buffer networks (glb_netwk_0..7) among the eight per-network clock-enable requesters of a design.
- Grants at most MAX_ACTIVE networks at once. Makes one grant change per decision and then waits a settling gap. Each grant is held for a minimum time before it can be revoked.
- Sits between the user-logic enable requests and the CLOCK_ENABLE/OUTPUT_ENABLE controls of the SB_GB_IO/SB_GB drivers. This limits simultaneous global-net toggling (supply inrush) and gives glitch-free, paced enable sequencing.

Parameters:
- NUM_NET, 8, number of global networks/requesters (1..8).
- MAX_ACTIVE, 4, maximum simultaneous grants (1..NUM_NET).
- SETTLE_CYCLES, 4, cycles spent in SETTLE after every grant change (>=1).
- MIN_HOLD, 16, minimum cycles a grant stays asserted before it may be revoked (>=1).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset. Clears all state immediately; state is held while high.
- req  input  NUM_NET  level request per network; bit i = domain i wants glb_netwk enabled.
- grant  output  NUM_NET  registered enable per network; drives the global buffer enable.
- active_cnt  output  4  registered popcount of grant.
- change  output  1  one-cycle pulse, registered, in the same cycle grant takes a new value.
- busy  output  1  high while in SETTLE.

Behaviour:
- Reset values:
  - grant=0, active_cnt=0, change=0, busy=0.
  - state=IDLE, rr_ptr=0, settle counter=0, all hold counters=0.
- Hold counters, one per net:
  - Cleared to 0 on the edge where that net's grant rises.
  - Increment by 1 each cycle while granted.
  - Saturate at MIN_HOLD; width is clog2(MIN_HOLD+1).
- Eligibility, evaluated combinationally in IDLE:
  - revoke_set = grant & ~req & (hold==MIN_HOLD).
  - pend_set = req & ~grant.
- IDLE decision, evaluated every cycle in IDLE:
  1. If revoke_set != 0: clear the lowest-index bit of revoke_set. Set change=1 and enter SETTLE.
  2. Else if pend_set != 0 and active_cnt < MAX_ACTIVE: set the first bit of pend_set searching upward from rr_ptr with wrap at NUM_NET-1 to 0. Set rr_ptr = (granted index + 1) mod NUM_NET, set change=1 and enter SETTLE.
  3. Else: no change; stay in IDLE.
  - Revocation has priority over granting in the same cycle.
  - Exactly one grant bit changes per decision.
- SETTLE:
  - busy=1.
  - Counter loads SETTLE_CYCLES-1 on entry and decrements each cycle. At 0 the FSM returns to IDLE on the next edge.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - No grant changes occur during SETTLE. req changes are ignored until IDLE.
- Latency: req rising on an idle scheduler with a free slot gives grant high after 1 clock edge, with change high in that same cycle. The next decision can happen no earlier than SETTLE_CYCLES+1 edges after a change.
- Early release: req dropping before hold reaches MIN_HOLD keeps grant high until the hold saturates. Revocation then occurs in the first IDLE cycle at or after saturation.
- Re-request: if req rises again while still granted (before revoke), nothing happens and the hold count continues.
- Full: with active_cnt == MAX_ACTIVE, pending requests wait. They are serviced in round-robin order as slots free.
- Fairness: a continuously requesting net waits at most NUM_NET-1 other grant decisions once a slot is free.
- Width rules:
  - active_cnt is the registered popcount, updated with grant.
  - rr_ptr is 3 bits with explicit wrap compare against NUM_NET-1. It must not rely on power-of-two overflow.
- Reset mid-SETTLE or mid-hold: all state clears asynchronously. After rst deasserts, the first decision can occur on the first edge.
- X-safety: unused bits of active_cnt are driven 0.

Test Plan:
1. Reset then req=8'h01: after 1 edge grant=8'h01, change=1 for one cycle, active_cnt=1, busy=1 for exactly 4 cycles.
2. req=8'hFF from idle: grants appear one at a time every 5 cycles in order 0,1,2,3. They stop at grant=8'h0F with active_cnt=4, and bits 4..7 remain 0.
3. From grant=8'h0F, hold saturated, req=8'hF0: bit 0 revoked first (grant=8'h0E), then 1,2,3 revoked before any new grant. Then 4,5,6,7 are granted, ending at grant=8'hF0.
4. req=8'h01 pulsed high for 2 cycles: grant[0] is held exactly until hold=16. It clears on the first IDLE edge thereafter, about 17 cycles after the rise.
5. MAX_ACTIVE=1, rr_ptr=3, pend=8'h09: bit 3 is granted before bit 0, and rr_ptr becomes 4.
6. rst asserted for 1 cycle during SETTLE with grant=8'h03: grant=0, busy=0 and change=0 immediately (asynchronous). With req still 8'h03, bit 0 is regranted on the first edge after release.

Source files
------------

// File: rtl/glb_netwk_sched.sv
// Paced scheduler sharing the global buffer networks among clock-enable requesters.
// One grant change per decision, followed by a settle gap; grants are held a minimum time.
module glb_netwk_sched #(
  parameter int NUM_NET       = 8,
  parameter int MAX_ACTIVE    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int MIN_HOLD      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_NET-1:0] req,
  output logic [NUM_NET-1:0] grant,
  output logic [3:0]         active_cnt,
  output logic               change,
  output logic               busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_MAX    = HW'(MIN_HOLD);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    MAX_CNT     = 4'(MAX_ACTIVE);
  localparam logic [3:0]    NET_CNT     = 4'(NUM_NET);
  localparam logic [2:0]    LAST_IDX    = 3'(NUM_NET - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_NET-1:0] grant_q, grant_d;
  logic [3:0]         active_cnt_q, active_cnt_d;
  logic               change_q, change_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [HW-1:0]      hold_q [NUM_NET];
  logic [HW-1:0]      hold_d [NUM_NET];

  logic [NUM_NET-1:0] revoke_set;
  logic [NUM_NET-1:0] pend_set;
  logic               found;
  logic [3:0]         cand;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    settle_d = settle_q;
    change_d = 1'b0;
    found    = 1'b0;
    cand     = 4'd0;

    for (int i = 0; i < NUM_NET; i++) begin
      revoke_set[i] = grant_q[i] & ~req[i] & (hold_q[i] == HOLD_MAX);
    end
    pend_set = req & ~grant_q;

    case (state_q)
      IDLE: begin
        if (|revoke_set) begin
          for (int i = 0; i < NUM_NET; i++) begin
            if (!found && revoke_set[i]) begin
              found      = 1'b1;
              grant_d[i] = 1'b0;
            end
          end
        end else if ((|pend_set) && (active_cnt_q < MAX_CNT)) begin
          // Round-robin search starting at rr_ptr, wrapping explicitly at NUM_NET.
          for (int off = 0; off < NUM_NET; off++) begin
            cand = {1'b0, rr_ptr_q} + 4'(off);
            if (cand >= NET_CNT) begin
              cand = cand - NET_CNT;
            end
            for (int j = 0; j < NUM_NET; j++) begin
              if (!found && (cand == 4'(j)) && pend_set[j]) begin
                found      = 1'b1;
                grant_d[j] = 1'b1;
                rr_ptr_d   = (cand[2:0] == LAST_IDX) ? 3'd0 : cand[2:0] + 3'd1;
              end
            end
          end
        end
        if (found) begin
          change_d = 1'b1;
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      default: begin
        if (settle_q == '0) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
    endcase

    active_cnt_d = 4'd0;
    for (int i = 0; i < NUM_NET; i++) begin
      active_cnt_d = active_cnt_d + {3'd0, grant_d[i]};
    end

    // Hold restarts at 0 on the rising grant and saturates while the grant stays high.
    for (int i = 0; i < NUM_NET; i++) begin
      hold_d[i] = '0;
      if (grant_q[i] && grant_d[i]) begin
        hold_d[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      active_cnt_q <= 4'd0;
      change_q     <= 1'b0;
      rr_ptr_q     <= 3'd0;
      settle_q     <= '0;
      for (int i = 0; i < NUM_NET; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      active_cnt_q <= active_cnt_d;
      change_q     <= change_d;
      rr_ptr_q     <= rr_ptr_d;
      settle_q     <= settle_d;
      for (int i = 0; i < NUM_NET; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign grant      = grant_q;
  assign active_cnt = active_cnt_q;
  assign change     = change_q;
  assign busy       = (state_q == SETTLE);

endmodule
